rv32i_mem_arbiter: RTL and testbench
====================================

# rv32i_mem_arbiter

Arbitrates one single-port, synchronous-read memory between the RV32I core's instruction-fetch port and its load/store port. Sits between the core and the unified memory inside `rv32i_system`. Issues at most one memory access per cycle and routes read data back to the requester that issued it. Data accesses have priority; a compile-time starvation guard can bound how long fetch waits.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: data width. Must be 32.
- `STARVE_LIMIT`, 4: consecutive denied fetch cycles before fetch is forced. Used only with the guard; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  global enable; low blocks new grants.
- `if_req`  in  1  fetch request; held until granted.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_gnt`  out  1  fetch accepted this cycle.
- `if_rvalid`  out  1  fetch data valid.
- `if_rdata`  out  DATA_W  fetch data.
- `d_req`  in  1  load/store request; held until granted.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  load/store byte address.
- `d_wdata`  in  DATA_W  store data.
- `d_wstrb`  in  4  store byte strobes.
- `d_gnt`  out  1  load/store accepted this cycle.
- `d_rvalid`  out  1  load data valid.
- `d_rdata`  out  DATA_W  load data.
- `mem_addr`  out  ADDR_W  word-aligned address; bits [1:0] are always 0.
- `mem_wr_ena`  out  1  memory write enable.
- `mem_wstrb`  out  4  memory byte strobes.
- `mem_wr_data`  out  DATA_W  memory write data.
- `mem_rd_data`  in  DATA_W  memory read data; valid one cycle after its address.

## Operation
- Each cycle with `ena`=1 and `rst`=0, the arbiter picks one winner from the asserted requests:
  - `d_req` wins over `if_req` by default.
  - Guard override is described under Configuration.
- The winner's `*_gnt` is asserted combinationally in that cycle, and `mem_*` is driven from its request.
- Non-winner behaviour:
  - `mem_wr_ena`=0 and `mem_wstrb`=0.
  - `mem_addr` holds its last value.
- Owner register (`OWNER_NONE`/`OWNER_IF`/`OWNER_D`) records the source of a granted read. A store leaves the owner at `OWNER_NONE`.
- Read return:
  - The owner register drives `if_rvalid`/`d_rvalid` in the next cycle.
  - `*_rdata` equals `mem_rd_data` while the matching rvalid is high, and 0 otherwise.
- Stores return no rvalid. They complete in their grant cycle.
- Back-to-back grants are permitted every cycle. A new grant can coincide with the rvalid of the previous read.
- `ena`=0:
  - No grants; `mem_wr_ena`=0.
  - A read granted in the previous cycle still returns its rvalid.
  - Guard counter holds its value.
- Requesters must hold address and data stable until `*_gnt`. The arbiter does not check this.

## Timing
- Reset, applied while `rst` is high and on the first cycle after it:
  - All `*_gnt`, `*_rvalid`, `mem_wr_ena` = 0.
  - `mem_wstrb`=0, `mem_addr`=0, `*_rdata`=0.
  - Owner = `OWNER_NONE`, guard counter = 0.
- Grant latency: 0 cycles (same cycle as a request that wins).
- Read latency: rvalid exactly 1 cycle after grant.
- Throughput: 1 access per cycle.
- Simultaneous `if_req` and `d_req`: exactly one grant, never both.
- Reset asserted in the cycle after a read grant: the pending rvalid is suppressed and the owner is cleared.

## Configuration
- Macro: `RV32I_ARB_STARVE_GUARD_EN`.
- Defined:
  - A 4-bit counter increments on each cycle where `if_req`=1, `d_gnt`=1 and `ena`=1.
  - When the counter equals `STARVE_LIMIT`, the next arbitration with `if_req`=1 grants fetch even if `d_req`=1.
  - The counter clears on any `if_gnt` and on any cycle with `if_req`=0.
- Undefined:
  - Strict data priority applies.
  - No counter is instantiated.
  - `STARVE_LIMIT` is ignored.

## Structure
- Package `rv32i_mem_pkg` holds:
  - `owner_t` enum: `OWNER_NONE`, `OWNER_IF`, `OWNER_D`.
  - Constants `WORD_BYTES`=4 and `STRB_W`=4.
  - `mem_word_addr()` function, which clears bits [1:0].
- Sub-module `rv32i_arb_starve_ctr` contains the counter and compare. It is instantiated only under `RV32I_ARB_STARVE_GUARD_EN`.

## Test plan
- Reset then fetch:
  - Hold `rst` 2 cycles; outputs must be 0 during and after reset.
  - `if_req`=1, `if_addr`=0x0000_0006 → `if_gnt`=1 with `mem_addr`=0x0000_0004.
  - Next cycle: `if_rvalid`=1 and `if_rdata`=mem word at 0x4.
- Store: `d_req`=1, `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF, `d_wstrb`=0xF.
  - `d_gnt`=1, `mem_wr_ena`=1, `mem_wstrb`=0xF.
  - No `d_rvalid` the following cycle.
- Contention:
  - `if_req` and `d_req` (load at 0x200) together → `d_gnt` only.
  - Next cycle: `d_rvalid`=1 and `if_gnt`=1.
  - Following cycle: `if_rvalid`=1.
- Starvation, guard defined with `STARVE_LIMIT`=4: both requests held continuously.
  - Grants are D,D,D,D,IF,D,D,D,D,IF.
  - With the guard undefined: D every cycle and `if_gnt` never asserts.
- Enable low with a pending read:
  - Load granted, then `ena`=0 with both requests held.
  - `d_rvalid`=1 the next cycle; no grants while `ena`=0.
  - Grants resume the cycle `ena` returns to 1.
- Reset mid-read:
  - Load granted, then `rst`=1 in the following cycle.
  - `d_rvalid` stays 0 and the owner returns to `OWNER_NONE`.

Source files
------------

// File: rtl/rv32i_mem_pkg.sv
// Shared types and helpers for the RV32I memory arbiter.
// Owner encoding, strobe width, and word-address alignment.
package rv32i_mem_pkg;

    localparam int unsigned WORD_BYTES     = 4;
    localparam int unsigned STRB_W         = 4;
    localparam int unsigned MEM_ADDR_W_MAX = 64;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_D    = 2'd2
    } owner_t;

    function automatic logic [MEM_ADDR_W_MAX-1:0] mem_word_addr(
        input logic [MEM_ADDR_W_MAX-1:0] byte_addr
    );
        return byte_addr & ~MEM_ADDR_W_MAX'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/rv32i_arb_starve_ctr.sv
// Fetch starvation guard: counts cycles in which a waiting fetch loses to data,
// and forces a fetch grant once the count reaches STARVE_LIMIT.
module rv32i_arb_starve_ctr #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ena_i,
    input  logic if_req_i,
    input  logic if_gnt_i,
    input  logic d_gnt_i,
    output logic force_if_o
);

    logic [3:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (!if_req_i || if_gnt_i) begin
            cnt_d = '0;
        end else if (ena_i && d_gnt_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_if_o = (cnt_q == 4'(STARVE_LIMIT));

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Single-port memory arbiter between RV32I fetch and load/store ports; data wins
// by default. Define RV32I_ARB_STARVE_GUARD_EN to bound fetch starvation.
module rv32i_mem_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [STRB_W-1:0] d_wstrb,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_ena,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    logic              grant_if, grant_d, force_if;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    owner_t            owner_q, owner_d;

`ifdef RV32I_ARB_STARVE_GUARD_EN
    rv32i_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk       (clk),
        .rst       (rst),
        .ena_i     (ena),
        .if_req_i  (if_req),
        .if_gnt_i  (grant_if),
        .d_gnt_i   (grant_d),
        .force_if_o(force_if)
    );
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT[3:0];
    assign force_if            = 1'b0;
`endif

    always_comb begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (ena && !rst) begin
            if (d_req && !(force_if && if_req)) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        owner_d     = OWNER_NONE;
        mem_wr_ena  = 1'b0;
        mem_wstrb   = '0;
        mem_wr_data = '0;
        if (grant_d) begin
            mem_addr_d = ADDR_W'(mem_word_addr(MEM_ADDR_W_MAX'(d_addr)));
            if (d_we) begin
                mem_wr_ena  = 1'b1;
                mem_wstrb   = d_wstrb;
                mem_wr_data = d_wdata;
            end else begin
                owner_d = OWNER_D;
            end
        end else if (grant_if) begin
            mem_addr_d = ADDR_W'(mem_word_addr(MEM_ADDR_W_MAX'(if_addr)));
            owner_d    = OWNER_IF;
        end
        if (rst) begin
            mem_addr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= OWNER_NONE;
            mem_addr_q <= '0;
        end else begin
            owner_q    <= owner_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Return path is gated by rst so a read in flight when reset arrives never reports.
    assign if_gnt    = grant_if;
    assign d_gnt     = grant_d;
    assign mem_addr  = mem_addr_d;
    assign if_rvalid = !rst && (owner_q == OWNER_IF);
    assign d_rvalid  = !rst && (owner_q == OWNER_D);
    assign if_rdata  = if_rvalid ? mem_rd_data : '0;
    assign d_rdata   = d_rvalid ? mem_rd_data : '0;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter: a cycle-level reference model checked
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_rv32i_mem_arbiter;

    localparam int LIMIT = 4;
`ifdef RV32I_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, ena;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_wr_ena;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wr_data;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rd_data = '0;
    logic [31:0] mem_words [0:1023];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv32i_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wr_ena(mem_wr_ena), .mem_wstrb(mem_wstrb),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous-read memory behind the arbiter.
    always @(posedge clk) begin
        if (mem_wr_ena) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) mem_words[mem_addr[11:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
            end
        end
        mem_rd_data <= mem_words[mem_addr[11:2]];
    end

    // Reference model: who should win, what read is outstanding, how long fetch has waited.
    int          m_pend = 0;      // 0 nothing, 1 fetch read, 2 data read
    logic [31:0] m_word = '0;
    logic [31:0] m_last = '0;
    int          m_wait = 0;

    always @(negedge clk) begin : model
        int          win;
        logic [31:0] e_addr;
        if (rst) begin
            check("m_rst_if_gnt", if_gnt, 0);
            check("m_rst_d_gnt", d_gnt, 0);
            check("m_rst_if_rvalid", if_rvalid, 0);
            check("m_rst_d_rvalid", d_rvalid, 0);
            check("m_rst_if_rdata", if_rdata, 0);
            check("m_rst_d_rdata", d_rdata, 0);
            check("m_rst_mem_addr", mem_addr, 0);
            check("m_rst_wr_ena", mem_wr_ena, 0);
            check("m_rst_wstrb", mem_wstrb, 0);
            m_pend = 0;
            m_last = '0;
            m_wait = 0;
        end else begin
            win = 0;
            if (ena) begin
                if (if_req && GUARD && m_wait >= LIMIT) win = 1;
                else if (d_req) win = 2;
                else if (if_req) win = 1;
            end
            e_addr = (win == 1) ? (if_addr & ~32'd3) : (win == 2) ? (d_addr & ~32'd3) : m_last;
            check("m_if_rvalid", if_rvalid, m_pend == 1);
            check("m_d_rvalid", d_rvalid, m_pend == 2);
            check("m_if_rdata", if_rdata, (m_pend == 1) ? m_word : 32'd0);
            check("m_d_rdata", d_rdata, (m_pend == 2) ? m_word : 32'd0);
            check("m_if_gnt", if_gnt, win == 1);
            check("m_d_gnt", d_gnt, win == 2);
            check("m_mem_addr", mem_addr, e_addr);
            check("m_wr_ena", mem_wr_ena, win == 2 && d_we);
            check("m_wstrb", mem_wstrb, (win == 2 && d_we) ? d_wstrb : 4'd0);
            if (win == 2 && d_we) check("m_wr_data", mem_wr_data, d_wdata);
            if (!if_req || win == 1) m_wait = 0;
            else if (win == 2) m_wait++;
            m_pend = (win == 1) ? 1 : (win == 2 && !d_we) ? 2 : 0;
            m_word = mem_words[e_addr[11:2]];
            m_last = e_addr;
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
    endtask

    task automatic load(input logic [31:0] a);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = a;
    endtask

    initial begin : stim
        for (int i = 0; i < 1024; i++) mem_words[i] = 32'h5000_0000 | 32'(i);
        mem_words[1]   = 32'h1234_5678;
        mem_words[16]  = 32'hA5A5_0040;
        mem_words[128] = 32'hCAFE_F00D;

        // Reset held two cycles with both requests asserted: nothing may be granted.
        rst = 1'b1; ena = 1'b1;
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0;
        d_addr = 32'h20; d_wdata = '0; d_wstrb = '0;
        @(negedge clk);
        check("rst_if_gnt", if_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        tick();
        @(negedge clk);
        check("rst_mem_addr", mem_addr, 0);
        tick();
        rst = 1'b0; idle();
        @(negedge clk);
        check("post_rst_if_rvalid", if_rvalid, 0);
        check("post_rst_mem_addr", mem_addr, 0);
        tick();

        // Fetch of an unaligned address.
        if_req = 1'b1; if_addr = 32'h0000_0006;
        @(negedge clk);
        check("fetch_gnt", if_gnt, 1);
        check("fetch_mem_addr", mem_addr, 32'h4);
        tick();
        idle();
        @(negedge clk);
        check("fetch_rvalid", if_rvalid, 1);
        check("fetch_rdata", if_rdata, 32'h1234_5678);
        tick();

        // Full store, then partial store, then load back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        @(negedge clk);
        check("store_gnt", d_gnt, 1);
        check("store_wr_ena", mem_wr_ena, 1);
        check("store_wstrb", mem_wstrb, 4'hF);
        tick();
        idle();
        @(negedge clk);
        check("store_no_rvalid", d_rvalid, 0);
        check("idle_addr_hold", mem_addr, 32'h100);
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h102; d_wdata = 32'h1111_2222; d_wstrb = 4'h3;
        tick();
        load(32'h100);
        tick();
        idle();
        @(negedge clk);
        check("partial_store_rdata", d_rdata, 32'hDEAD_2222);
        tick();

        // Contention: data wins, fetch follows while the load returns.
        if_req = 1'b1; if_addr = 32'h40; load(32'h200);
        @(negedge clk);
        check("cont_d_gnt", d_gnt, 1);
        check("cont_if_gnt", if_gnt, 0);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        check("cont_d_rvalid", d_rvalid, 1);
        check("cont_d_rdata", d_rdata, 32'hCAFE_F00D);
        check("cont_if_gnt2", if_gnt, 1);
        check("cont_mem_addr", mem_addr, 32'h40);
        tick();
        idle();
        @(negedge clk);
        check("cont_if_rvalid", if_rvalid, 1);
        check("cont_if_rdata", if_rdata, 32'hA5A5_0040);
        tick();

        // Starvation: both held for ten cycles.
        if_req = 1'b1; if_addr = 32'h8; load(32'h300);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("starve_if_gnt", if_gnt, GUARD && (i % 5 == 4));
            check("starve_d_gnt", d_gnt, !(GUARD && (i % 5 == 4)));
            tick();
        end
        idle();
        tick();

        // Enable low with a load in flight.
        if_req = 1'b1; if_addr = 32'hC; load(32'h200);
        @(negedge clk);
        check("ena_load_gnt", d_gnt, 1);
        tick();
        ena = 1'b0;
        @(negedge clk);
        check("ena_low_rvalid", d_rvalid, 1);
        check("ena_low_rdata", d_rdata, 32'hCAFE_F00D);
        check("ena_low_d_gnt", d_gnt, 0);
        check("ena_low_if_gnt", if_gnt, 0);
        tick();
        @(negedge clk);
        check("ena_low2_rvalid", d_rvalid, 0);
        check("ena_low2_gnts", {if_gnt, d_gnt}, 0);
        tick();
        ena = 1'b1;
        @(negedge clk);
        check("ena_resume_gnt", d_gnt, 1);
        tick();
        idle();
        tick();

        // Reset in the cycle after a load grant.
        load(32'h200);
        @(negedge clk);
        check("rmid_gnt", d_gnt, 1);
        tick();
        idle(); rst = 1'b1;
        @(negedge clk);
        check("rmid_rvalid", d_rvalid, 0);
        check("rmid_rdata", d_rdata, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rmid_after_rvalid", d_rvalid, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
